td4_decode_ctrl: RTL
====================

TD4_DECODE_CTRL -- requirements
Module: td4_decode_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port CLR, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port Order, input, 8, ROM instruction word; opcode Order[7:4], immediate Order[3:0].
REQ-004 SHALL have port Address, input, 4, current PC value.
REQ-005 SHALL have port CarryFlag, input, 1, registered carry from flag register.
REQ-006 SHALL have ports Run (input, 1, level: free-run request) and Step (input, 1, rising edge: single-instruction request).
REQ-007 SHALL have port EN, output, 1, execute enable to all registers and PC.
REQ-008 SHALL have ports LOAD0, LOAD1, LOAD2, LOAD3, output, 1 each: load A, B, OUT, PC.
REQ-009 SHALL have ports SelA and SelB, output, 1 each: ALU source mux; 00=A, 01=B, 10=IN, 11=zero.
REQ-010 SHALL have port Im, output, 4, equal to Order[3:0] at all times.
REQ-011 SHALL have ports Halted (output, 1), IllegalOp (output, 1) and InstrCount (output, 8).

Function
REQ-012 SHALL decode: 0000 ADD A,Im sel00/LOAD0; 0101 ADD B,Im sel01/LOAD1; 0011 MOV A,Im sel11/LOAD0; 0111 MOV B,Im sel11/LOAD1; 0001 MOV A,B sel01/LOAD0; 0100 MOV B,A sel00/LOAD1; 0010 IN A sel10/LOAD0; 0110 IN B sel10/LOAD1; 1001 OUT B sel01/LOAD2; 1011 OUT Im sel11/LOAD2; 1111 JMP sel11/LOAD3; 1110 JNC sel11/LOAD3 only when CarryFlag=0.
REQ-013 SHALL treat opcodes 1000, 1010, 1100, 1101 as NOP: no LOADn, sel 11, IllegalOp=1; PC still advances.
REQ-014 SHALL drive each LOADn as decoded-load AND EN, combinationally, zero latency from Order.
REQ-015 SHALL implement FSM states HALT, RUN, STEP; EN=1 in RUN and STEP, EN=0 in HALT; Halted=1 only in HALT.
REQ-016 SHALL transition HALT->RUN when Run=1; else HALT->STEP on Step rising edge; Run takes priority over Step.
REQ-017 SHALL transition STEP->HALT unconditionally after exactly one EN cycle.
REQ-018 SHALL transition RUN->HALT when Run=0; Step ignored in RUN.
REQ-019 SHALL detect Step rising edge with a registered previous Step sample; a held-high Step yields exactly one STEP.
REQ-020 SHALL increment InstrCount by 1 on each cycle with EN=1; wrap 255->0.

Reset
REQ-021 SHALL, on CLR=1 at a clock edge, force state HALT, InstrCount=0, Step sample=0, overriding all other transitions including mid-RUN and mid-STEP.
REQ-022 SHALL after reset present EN=0, all LOADn=0, Halted=1; SelA/SelB/Im/IllegalOp follow Order.

Configuration
REQ-023 SHALL support macro TD4_SELFLOOP_HALT_EN.
REQ-024 SHALL, with TD4_SELFLOOP_HALT_EN defined, on an executed JMP (or taken JNC) whose Im equals Address while in RUN, execute that cycle then transition RUN->HALT.
REQ-025 SHALL, without the macro, have no self-loop detection; RUN left only by Run=0 or CLR.

Structure
REQ-026 SHALL place opcode constants, sel encodings and FSM state typedef in shared package td4_pkg.
REQ-027 SHALL place the pure opcode-to-control decode in sub-module td4_opdecode; FSM, edge detect and counter stay in td4_decode_ctrl.

Verification
REQ-028 SHALL check: CLR=1 for 2 cycles, Run=1 -> EN=0, Halted=1, InstrCount=0 during reset; EN=1 first cycle after release.
REQ-029 SHALL check: HALT, Order=8'h35, Step held high 5 cycles -> EN=1 for exactly one cycle, LOAD0=1 that cycle, InstrCount=1.
REQ-030 SHALL check: RUN, Order=8'hE7 with CarryFlag=1 -> LOAD3=0; CarryFlag=0 -> LOAD3=1, sel 11, Im=7.
REQ-031 SHALL check: RUN, Order=8'h80 -> IllegalOp=1, all LOADn=0, EN=1, InstrCount increments.
REQ-032 SHALL check: macro defined, RUN, Order=8'hF3, Address=3 -> LOAD3=1 that cycle, Halted=1 next cycle; macro undefined -> stays RUN.
REQ-033 SHALL check: InstrCount=255, one RUN cycle -> InstrCount=0.

Source files
------------

// File: rtl/td4_pkg.sv
// td4_pkg: shared opcodes, load one-hots, ALU source encodings ({SelB,SelA}) and controller states.
package td4_pkg;
  typedef enum logic [1:0] {HALT, RUN, STEP} state_t;
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;
  localparam logic [3:0] LD_A   = 4'b0001;
  localparam logic [3:0] LD_B   = 4'b0010;
  localparam logic [3:0] LD_OUT = 4'b0100;
  localparam logic [3:0] LD_PC  = 4'b1000;
  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;
endpackage

// File: rtl/td4_opdecode.sv
// td4_opdecode: pure opcode-to-control decode; unlisted opcodes are NOPs that flag illegal.
module td4_opdecode
  import td4_pkg::*;
(
  input  logic [3:0] op,
  input  logic       carry,
  output logic [3:0] ld,
  output logic [1:0] sel,
  output logic       illegal
);
  always_comb begin
    ld = 4'b0000;
    sel = SEL_ZERO;
    illegal = 1'b0;
    case (op)
      OP_ADD_A:  begin ld = LD_A;   sel = SEL_A;    end
      OP_ADD_B:  begin ld = LD_B;   sel = SEL_B;    end
      OP_MOV_AI: begin ld = LD_A;   sel = SEL_ZERO; end
      OP_MOV_BI: begin ld = LD_B;   sel = SEL_ZERO; end
      OP_MOV_AB: begin ld = LD_A;   sel = SEL_B;    end
      OP_MOV_BA: begin ld = LD_B;   sel = SEL_A;    end
      OP_IN_A:   begin ld = LD_A;   sel = SEL_IN;   end
      OP_IN_B:   begin ld = LD_B;   sel = SEL_IN;   end
      OP_OUT_B:  begin ld = LD_OUT; sel = SEL_B;    end
      OP_OUT_I:  begin ld = LD_OUT; sel = SEL_ZERO; end
      OP_JMP:    ld = LD_PC;
      OP_JNC:    ld = carry ? 4'b0000 : LD_PC;
      default:   illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/td4_decode_ctrl.sv
// td4_decode_ctrl: TD4 decode plus HALT/RUN/STEP execute control and instruction counter.
// Optional TD4_SELFLOOP_HALT_EN: a taken jump to its own address halts a free run.
module td4_decode_ctrl
  import td4_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] Order,
  input  logic [3:0] Address,
  input  logic       CarryFlag,
  input  logic       Run,
  input  logic       Step,
  output logic       EN,
  output logic       LOAD0,
  output logic       LOAD1,
  output logic       LOAD2,
  output logic       LOAD3,
  output logic       SelA,
  output logic       SelB,
  output logic [3:0] Im,
  output logic       Halted,
  output logic       IllegalOp,
  output logic [7:0] InstrCount
);
  state_t state, state_n;
  logic step_prev, step_rise, self_loop;
  logic [3:0] ld;
  logic [1:0] sel;
  td4_opdecode u_dec (
    .op(Order[7:4]),
    .carry(CarryFlag),
    .ld(ld),
    .sel(sel),
    .illegal(IllegalOp)
  );
  assign EN = state != HALT;
  assign Halted = state == HALT;
  assign {LOAD3, LOAD2, LOAD1, LOAD0} = ld & {4{EN}};
  assign {SelB, SelA} = sel;
  assign Im = Order[3:0];
  assign step_rise = Step & ~step_prev;
`ifdef TD4_SELFLOOP_HALT_EN
  assign self_loop = ld[3] && Im == Address;
`else
  logic unused_addr;
  assign unused_addr = ^Address;
  assign self_loop = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      HALT:    state_n = Run ? RUN : step_rise ? STEP : HALT;
      RUN:     state_n = (!Run || self_loop) ? HALT : RUN;
      STEP:    state_n = HALT;
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= HALT;
      step_prev <= 1'b0;
      InstrCount <= 8'd0;
    end else begin
      state <= state_n;
      step_prev <= Step;
      InstrCount <= InstrCount + {7'd0, EN};
    end
  end
endmodule
